// File: rtl/multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl
//
// Pipeline-side sequencer for a multi-cycle multiply/divide unit. When a mul or
// div reaches Execute, the pipeline is stalled and a one-cycle start pulse goes
// to the multdiv unit. The controller waits for md_ready, or gives up after a
// timeout, and then presents the result for one cycle on wr_reg/wr_data. On an
// exception (overflow, divide-by-zero or timeout) the write goes to rstatus
// (r30) with code 4 (mul) or 5 (div). A flush during START or BUSY abandons the
// operation.
//
// Parameters
//   TIMEOUT_CYCLES  max BUSY cycles before a forced exception (1..63)
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset
//   ex_is_mult     Execute holds a mul
//   ex_is_div      Execute holds a div
//   ex_rd          destination register of the Execute instruction
//   flush          branch/jump redirect, kills an in-flight operation
//   md_ready       multdiv unit result ready
//   md_result      multdiv unit result
//   md_exception   multdiv unit overflow / divide-by-zero
//   ctrl_MULT      registered one-cycle start pulse for mul
//   ctrl_DIV       registered one-cycle start pulse for div
//   stall          freezes PC and pipeline latches (combinational)
//   result_valid   registered one-cycle qualifier on wr_reg/wr_data
//   wr_reg         destination register of the completed operation
//   wr_data        value to write
//   busy_cycles    BUSY cycles of the current or last operation (saturating)
// -----------------------------------------------------------------------------
module multdiv_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 40
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_is_mult,
   input  logic        ex_is_div,
   input  logic [4:0]  ex_rd,
   input  logic        flush,
   input  logic        md_ready,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic        stall,
   output logic        result_valid,
   output logic [4:0]  wr_reg,
   output logic [31:0] wr_data,
   output logic [5:0]  busy_cycles
);

   typedef enum logic [1:0] {StIdle, StStart, StBusy, StDone} state_e;

   localparam logic [5:0] TimeoutLast = 6'(TIMEOUT_CYCLES - 1);
   localparam logic [5:0] BusyMax     = 6'd63;
   localparam logic [4:0] RstatusReg  = 5'd30;

   state_e      state_q, state_d;
   logic        op_mul_q;
   logic [4:0]  rd_q;
   logic [5:0]  busy_q;
   logic        ctrl_mult_q, ctrl_div_q, result_valid_q;
   logic [4:0]  wr_reg_q;
   logic [31:0] wr_data_q;

   logic        issue;
   logic        timeout;
   logic        finish;
   logic        exc_next;

   // Accept only from IDLE; a redirect in the same cycle kills the issue.
   assign issue   = (state_q == StIdle) & (ex_is_mult | ex_is_div) & ~flush;
   assign timeout = (busy_q == TimeoutLast);
   // md_ready has priority over the timeout; flush overrides both.
   assign finish  = (state_q == StBusy) & ~flush & (md_ready | timeout);
   assign exc_next = md_ready ? md_exception : 1'b1;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (issue) begin
               state_d = StStart;
            end
         end
         StStart: begin
            state_d = flush ? StIdle : StBusy;
         end
         StBusy: begin
            if (flush) begin
               state_d = StIdle;
            end else if (md_ready || timeout) begin
               state_d = StDone;
            end
         end
         StDone: begin
            // Flush and ex_is_* are ignored here; the result always retires.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic (combinational stall)
   // ---------------------------------------------------------------------------
   always_comb begin
      stall = 1'b0;
      if (reset) begin
         unique case (state_q)
            StIdle:          stall = issue;
            StStart, StBusy: stall = ~flush;
            default:         stall = 1'b0;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Captured operation, BUSY counter and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_mul_q       <= 1'b0;
         rd_q           <= '0;
         busy_q         <= '0;
         ctrl_mult_q    <= 1'b0;
         ctrl_div_q     <= 1'b0;
         result_valid_q <= 1'b0;
         wr_reg_q       <= '0;
         wr_data_q      <= '0;
      end else begin
         ctrl_mult_q    <= issue & ex_is_mult;
         ctrl_div_q     <= issue & ~ex_is_mult;
         result_valid_q <= finish;

         if (issue) begin
            op_mul_q <= ex_is_mult;
            rd_q     <= ex_rd;
            busy_q   <= '0;
         end else if ((state_q == StBusy) && (busy_q != BusyMax)) begin
            busy_q <= busy_q + 6'd1;
         end

         if (finish) begin
            if (exc_next) begin
               wr_reg_q  <= RstatusReg;
               wr_data_q <= op_mul_q ? 32'd4 : 32'd5;
            end else begin
               wr_reg_q  <= rd_q;
               wr_data_q <= md_result;
            end
         end
      end
   end

   assign ctrl_MULT    = ctrl_mult_q;
   assign ctrl_DIV     = ctrl_div_q;
   assign result_valid = result_valid_q;
   assign wr_reg       = wr_reg_q;
   assign wr_data      = wr_data_q;
   assign busy_cycles  = busy_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multdiv_ctrl
//
// Directed bench for multdiv_ctrl. A table of operations with hand-computed
// results is run back to back; hand-written sequences cover reset, flush and
// asynchronous reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_multdiv_ctrl;

   logic        clock;
   logic        reset;
   logic        ex_is_mult;
   logic        ex_is_div;
   logic [4:0]  ex_rd;
   logic        flush;
   logic        md_ready;
   logic [31:0] md_result;
   logic        md_exception;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic        stall;
   logic        result_valid;
   logic [4:0]  wr_reg;
   logic [31:0] wr_data;
   logic [5:0]  busy_cycles;

   int checks   = 0;
   int failures = 0;

   multdiv_ctrl #(
      .TIMEOUT_CYCLES(40)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .ex_is_mult  (ex_is_mult),
      .ex_is_div   (ex_is_div),
      .ex_rd       (ex_rd),
      .flush       (flush),
      .md_ready    (md_ready),
      .md_result   (md_result),
      .md_exception(md_exception),
      .ctrl_MULT   (ctrl_MULT),
      .ctrl_DIV    (ctrl_DIV),
      .stall       (stall),
      .result_valid(result_valid),
      .wr_reg      (wr_reg),
      .wr_data     (wr_data),
      .busy_cycles (busy_cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        m;
      logic        d;
      logic [4:0]  rd;
      int          lat;     // BUSY cycle (1 = first) carrying md_ready; 0 = never
      logic [31:0] res;
      logic        exc;
      logic [4:0]  e_reg;
      logic [31:0] e_data;
      logic [5:0]  e_busy;
      int          e_done;  // cycle of result_valid counted from the START cycle (0)
      int          e_pm;
      int          e_pd;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Move to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Entered and left 1 unit after a rising edge with the DUT in IDLE.
   task automatic run_op(input vec_t v, input int idx);
      int  pm = 0;
      int  pd = 0;
      int  stall_bad = 0;
      int  done_c = -1;
      bit  seen = 1'b0;
      ex_is_mult = v.m;
      ex_is_div  = v.d;
      ex_rd      = v.rd;
      #1;
      check($sformatf("v%0d issue_stall", idx), 32'(stall), 32'd1);
      tick();
      ex_is_mult = 1'b0;
      ex_is_div  = 1'b0;
      ex_rd      = 5'd0;
      for (int c = 0; c < 100 && !seen; c++) begin
         md_ready     = (v.lat != 0) && (c == v.lat);
         md_result    = v.res;
         md_exception = v.exc;
         #1;
         pm += int'(ctrl_MULT);
         pd += int'(ctrl_DIV);
         if (result_valid) begin
            seen   = 1'b1;
            done_c = c;
            check($sformatf("v%0d done_stall", idx), 32'(stall), 32'd0);
            check($sformatf("v%0d wr_reg", idx), 32'(wr_reg), 32'(v.e_reg));
            check($sformatf("v%0d wr_data", idx), wr_data, v.e_data);
            check($sformatf("v%0d busy_cycles", idx), 32'(busy_cycles), 32'(v.e_busy));
         end else begin
            if (!stall) stall_bad++;
            tick();
         end
      end
      md_ready = 1'b0;
      check($sformatf("v%0d done_cycle", idx), 32'(done_c), 32'(v.e_done));
      check($sformatf("v%0d stall_held", idx), 32'(stall_bad), 32'd0);
      tick();
      pm += int'(ctrl_MULT);
      pd += int'(ctrl_DIV);
      check($sformatf("v%0d rv_one_cycle", idx), 32'(result_valid), 32'd0);
      check($sformatf("v%0d mult_pulses", idx), 32'(pm), 32'(v.e_pm));
      check($sformatf("v%0d div_pulses", idx), 32'(pd), 32'(v.e_pd));
   endtask

   // Issue an op, flush in cycle fc (0 = START), md_ready 10 cycles later.
   task automatic flush_seq(input bit m, input int fc, input string tag);
      int pm = 0;
      int pd = 0;
      int rv = 0;
      ex_is_mult = m;
      ex_is_div  = ~m;
      ex_rd      = 5'd7;
      tick();
      ex_is_mult = 1'b0;
      ex_is_div  = 1'b0;
      for (int c = 0; c < 20; c++) begin
         flush        = (c == fc);
         md_ready     = (c == fc + 10);
         md_result    = 32'h1111_2222;
         md_exception = 1'b0;
         #1;
         pm += int'(ctrl_MULT);
         pd += int'(ctrl_DIV);
         rv += int'(result_valid);
         if (c == fc) check({tag, " stall_drop"}, 32'(stall), 32'd0);
         if (c == fc + 1) check({tag, " idle_stall"}, 32'(stall), 32'd0);
         tick();
      end
      flush    = 1'b0;
      md_ready = 1'b0;
      check({tag, " no_result"}, 32'(rv), 32'd0);
      check({tag, " mult_pulses"}, 32'(pm), m ? 32'd1 : 32'd0);
      check({tag, " div_pulses"}, 32'(pd), m ? 32'd0 : 32'd1);
   endtask

   initial begin
      //           m     d     rd     lat res            exc   e_reg  e_data         busy   done pm pd
      vecs[0] = '{1'b1, 1'b0, 5'd5,  17, 32'h0000_0C00, 1'b0, 5'd5,  32'h0000_0C00, 6'd17, 18,  1, 0};
      vecs[1] = '{1'b0, 1'b1, 5'd7,  4,  32'h0000_1234, 1'b1, 5'd30, 32'd5,         6'd4,  5,   0, 1};
      vecs[2] = '{1'b1, 1'b0, 5'd9,  0,  32'h0000_0000, 1'b0, 5'd30, 32'd4,         6'd40, 41,  1, 0};
      vecs[3] = '{1'b1, 1'b0, 5'd3,  2,  32'hDEAD_BEEF, 1'b0, 5'd3,  32'hDEAD_BEEF, 6'd2,  3,   1, 0};
      vecs[4] = '{1'b0, 1'b1, 5'd3,  1,  32'h0000_0007, 1'b0, 5'd3,  32'h0000_0007, 6'd1,  2,   0, 1};
      vecs[5] = '{1'b1, 1'b1, 5'd12, 3,  32'hAAAA_5555, 1'b0, 5'd12, 32'hAAAA_5555, 6'd3,  4,   1, 0};
      vecs[6] = '{1'b0, 1'b1, 5'd1,  40, 32'h0000_0055, 1'b0, 5'd1,  32'h0000_0055, 6'd40, 41,  0, 1};
      vecs[7] = '{1'b0, 1'b1, 5'd4,  0,  32'h0000_0000, 1'b0, 5'd30, 32'd5,         6'd40, 41,  0, 1};
      vecs[8] = '{1'b1, 1'b0, 5'd2,  5,  32'h0000_0099, 1'b1, 5'd30, 32'd4,         6'd5,  6,   1, 0};

      reset        = 1'b0;
      ex_is_mult   = 1'b1;
      ex_is_div    = 1'b0;
      ex_rd        = 5'd4;
      flush        = 1'b0;
      md_ready     = 1'b0;
      md_result    = 32'd0;
      md_exception = 1'b0;

      // Reset state, with an issue request pending.
      #12;
      check("rst stall", 32'(stall), 32'd0);
      check("rst ctrl_MULT", 32'(ctrl_MULT), 32'd0);
      check("rst ctrl_DIV", 32'(ctrl_DIV), 32'd0);
      check("rst result_valid", 32'(result_valid), 32'd0);
      check("rst wr_reg", 32'(wr_reg), 32'd0);
      check("rst wr_data", wr_data, 32'd0);
      check("rst busy_cycles", 32'(busy_cycles), 32'd0);

      // Release mid-cycle; the first edge afterwards accepts the mul.
      #10;
      reset = 1'b1;
      #1;
      check("first issue_stall", 32'(stall), 32'd1);
      tick();
      check("first ctrl_MULT", 32'(ctrl_MULT), 32'd1);
      ex_is_mult = 1'b0;
      tick();
      md_ready  = 1'b1;
      md_result = 32'h0000_0011;
      tick();
      md_ready = 1'b0;
      check("first rv", 32'(result_valid), 32'd1);
      check("first wr_reg", 32'(wr_reg), 32'd4);
      check("first wr_data", wr_data, 32'h0000_0011);
      check("first busy", 32'(busy_cycles), 32'd1);
      tick();

      // Table of operations, issued back to back.
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i], i);
      end

      // Flush in the 3rd BUSY cycle and in START.
      flush_seq(1'b0, 3, "flush_busy3");
      flush_seq(1'b1, 0, "flush_start");

      // Asynchronous reset mid-BUSY.
      ex_is_mult = 1'b1;
      ex_rd      = 5'd6;
      tick();
      ex_is_mult = 1'b0;
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      check("arst stall", 32'(stall), 32'd0);
      check("arst result_valid", 32'(result_valid), 32'd0);
      check("arst wr_reg", 32'(wr_reg), 32'd0);
      check("arst wr_data", wr_data, 32'd0);
      check("arst busy_cycles", 32'(busy_cycles), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      tick();
      begin
         int rv = 0;
         md_ready = 1'b1;
         for (int c = 0; c < 5; c++) begin
            #1;
            rv += int'(result_valid) + int'(stall);
            tick();
            md_ready = 1'b0;
         end
         check("arst abandoned", 32'(rv), 32'd0);
      end
      run_op(vecs[3], 9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
